cpu_trace_monitor: RTL

//  Sits beside the tinycpu core inside sim_env. It consumes the controller state,
//  the current opcode and the rA/rB/rM/rP register outputs.

---
 rtl/cpu_trace_monitor_pkg.sv | 11 +
 rtl/cpu_trace_monitor_fifo.sv | 54 +++++
 rtl/cpu_trace_monitor.sv | 78 +++++++
 3 files changed

// File: rtl/cpu_trace_monitor_pkg.sv
// Shared constants for the tinycpu trace monitor: controller state codes and opcodes.
package cpu_trace_monitor_pkg;

    // Controller one-hot state codes used by the monitor
    localparam logic [5:0] ST_IDLE = 6'b100000;
    localparam logic [5:0] ST_EXEC = 6'b001000;

    // Opcode field (instruction bits [7:6]) for an unconditional jump
    localparam logic [1:0] OP_JMP = 2'b11;

endpackage

// File: rtl/cpu_trace_monitor_fifo.sv
// Trace FIFO: register array with wrapping pointers and an explicit level counter.
// The caller gates push/pop; the head is presented straight from the storage array.
module cpu_trace_monitor_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    // Head reads zero when empty so outputs are clean straight out of reset
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and level; pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Trace monitor beside the tinycpu core: snapshots registers on every IDLE cycle into a
// FIFO and latches a sticky halt flag when the core executes a jump to itself.
module cpu_trace_monitor
    import cpu_trace_monitor_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              state_i,
    input  logic [1:0]              instr_op_i,
    input  logic [DATA_W-1:0]       ra_i,
    input  logic [DATA_W-1:0]       rb_i,
    input  logic [DATA_W-1:0]       rm_i,
    input  logic [DATA_W-1:0]       rp_i,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [4*DATA_W-1:0]     trace_data_o,
    output logic                    halt_o,
    output logic [CNT_W-1:0]        instr_count_o,
    output logic [CNT_W-1:0]        drop_count_o,
    output logic [$clog2(DEPTH):0]  fifo_level_o
);

    logic capture;
    logic pop;
    logic push;
    logic full;
    logic empty;
    logic halt_hit;

    assign capture       = (state_i == ST_IDLE) && !halt_o;
    assign trace_valid_o = !empty;
    assign pop           = trace_valid_o && trace_ready_i;
    // A pop frees the slot this cycle, so a full FIFO still accepts a simultaneous capture
    assign push          = capture && (!full || pop);
    // P has already advanced past the jump, so P-1 == M means the jump targets itself
    assign halt_hit      = (state_i == ST_EXEC) && (instr_op_i == OP_JMP)
                           && ((rp_i - DATA_W'(1)) == rm_i);

    cpu_trace_monitor_fifo #(
        .WIDTH (4 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({ra_i, rb_i, rm_i, rp_i}),
        .pop       (pop),
        .head_data (trace_data_o),
        .level     (fifo_level_o),
        .full      (full),
        .empty     (empty)
    );

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_o <= 1'b0;
        end else if (halt_hit) begin
            halt_o <= 1'b1;
        end
    end

    // Saturating snapshot and drop counters
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_o <= '0;
            drop_count_o  <= '0;
        end else if (capture) begin
            if (instr_count_o != '1) instr_count_o <= instr_count_o + CNT_W'(1);
            if (!push && drop_count_o != '1) drop_count_o <= drop_count_o + CNT_W'(1);
        end
    end

endmodule
